// File: rtl/axis_gen_store_forward.sv
// AXI-Stream packet source (pattern generator or slave port) feeding a circular
// store-and-forward buffer that releases only complete packets on the master port.
module axis_gen_store_forward #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4096,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    LEN_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 32'h80200003
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [LEN_WIDTH-1:0]      pkt_len,
  input  logic [DATA_WIDTH-1:0]     seed,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  output logic [ADDR_WIDTH:0]       fill_level,
  output logic [15:0]               pkt_sent_count,
  output logic [15:0]               drop_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PW         = ADDR_WIDTH + 1;
  localparam int MEM_W      = 1 + STRB_WIDTH + DATA_WIDTH;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_EXT   = 2'd3;

  typedef enum logic [1:0] {IDLE, GEN, EXT, DROP} wr_state_t;

  wr_state_t             state, state_nxt;
  logic [MEM_W-1:0]      mem [DEPTH];
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic [PW-1:0]         len_q, word_cnt, eff_len;
  logic [1:0]            cur_mode;
  logic [DATA_WIDTH-1:0] gen_value;
  logic                  full, gen_last;
  logic                  wr_en, rewind, drop_pkt;
  logic [MEM_W-1:0]      wr_data;
  logic [MEM_W-1:0]      a_data;
  logic                  a_valid, out_valid;
  logic                  out_fire, b_load, fetch;

  function automatic logic [DATA_WIDTH-1:0] load_value(input logic [1:0] m,
                                                       input logic [DATA_WIDTH-1:0] s);
    // An all-zero LFSR would lock up, so a zero seed starts it at 1.
    if (m == MODE_LFSR && s == '0) return {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_value(input logic [1:0] m,
                                                       input logic [DATA_WIDTH-1:0] v,
                                                       input logic [DATA_WIDTH-1:0] s);
    case (m)
      MODE_INC:   return v + DATA_WIDTH'(1);
      MODE_CONST: return s;
      MODE_LFSR:  return {v[DATA_WIDTH-2:0], ^(v & LFSR_TAPS)};
      default:    return v;
    endcase
  endfunction

  assign fill_level = wr_ptr - rd_ptr;
  assign full       = (fill_level == PW'(DEPTH));
  assign gen_last   = (word_cnt == len_q - PW'(1));

  always_comb begin
    if (pkt_len == '0)                       eff_len = PW'(1);
    else if (32'(pkt_len) > 32'(DEPTH))      eff_len = PW'(DEPTH);
    else                                     eff_len = PW'(pkt_len);
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    wr_en           = 1'b0;
    wr_data         = '0;
    rewind          = 1'b0;
    drop_pkt        = 1'b0;
    s00_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_EXT) state_nxt = EXT;
        else if (enable)      state_nxt = GEN;
      end
      GEN: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = {gen_last, {STRB_WIDTH{1'b1}}, gen_value};
          if (gen_last) state_nxt = IDLE;
        end
      end
      EXT: begin
        s00_axis_tready = !full;
        // Full with nothing committed: this packet can never drain, so drop it.
        if (full && commit_ptr == rd_ptr) begin
          rewind    = 1'b1;
          state_nxt = DROP;
        end else if (s00_axis_tvalid && !full) begin
          wr_en   = 1'b1;
          wr_data = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
          if (s00_axis_tlast) state_nxt = IDLE;
        end
      end
      DROP: begin
        s00_axis_tready = 1'b1;
        if (s00_axis_tvalid && s00_axis_tlast) begin
          drop_pkt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      word_cnt   <= '0;
      len_q      <= PW'(1);
      cur_mode   <= mode;
      gen_value  <= load_value(mode, seed);
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (wr_en && wr_data[MEM_W-1]) commit_ptr <= wr_ptr + PW'(1);
      if (drop_pkt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      case (state)
        IDLE: begin
          len_q    <= eff_len;
          word_cnt <= '0;
          cur_mode <= mode;
          if (mode != cur_mode) gen_value <= load_value(mode, seed);
        end
        GEN: begin
          if (wr_en) begin
            word_cnt  <= word_cnt + PW'(1);
            gen_value <= next_value(cur_mode, gen_value, seed);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the buffer array and its read register carry no reset; pointers define validity.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    if (fetch) a_data <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
  end

  // Two-stage read pipeline: memory read register, then the output register.
  // rd_ptr only moves on a transfer, so prefetched words still count as held.
  assign m00_axis_tvalid = out_valid && !axis_areset;
  assign out_fire        = m00_axis_tvalid && m00_axis_tready;
  assign b_load          = a_valid && (!out_valid || m00_axis_tready);
  assign fetch           = (fetch_ptr != commit_ptr) && (!a_valid || b_load);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      fetch_ptr      <= '0;
      rd_ptr         <= '0;
      a_valid        <= 1'b0;
      out_valid      <= 1'b0;
      m00_axis_tdata <= '0;
      m00_axis_tstrb <= '0;
      m00_axis_tlast <= 1'b0;
      pkt_sent_count <= '0;
    end else begin
      if (out_fire) rd_ptr <= rd_ptr + PW'(1);
      if (out_fire && m00_axis_tlast) pkt_sent_count <= pkt_sent_count + 16'd1;
      if (fetch) begin
        fetch_ptr <= fetch_ptr + PW'(1);
        a_valid   <= 1'b1;
      end else if (b_load) begin
        a_valid   <= 1'b0;
      end
      if (b_load) begin
        {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} <= a_data;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_gen_store_forward.sv
// Scoreboard bench for axis_gen_store_forward: stimulus pushes expected beats,
// a negedge monitor pops and compares every output transfer and checks stall stability.
module tb_axis_gen_store_forward;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 12;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          axis_areset;
  logic          enable;
  logic [1:0]    mode;
  logic [LW-1:0] pkt_len;
  logic [DW-1:0] seed;
  logic [DW-1:0] s00_axis_tdata;
  logic [SW-1:0] s00_axis_tstrb;
  logic          s00_axis_tvalid;
  logic          s00_axis_tlast;
  logic          s00_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic          m00_axis_tready;
  logic [AW:0]   fill_level;
  logic [15:0]   pkt_sent_count;
  logic [15:0]   drop_count;

  axis_gen_store_forward #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .LFSR_TAPS(32'h80200003)
  ) dut (
    .axis_aclk      (clk),
    .axis_areset    (axis_areset),
    .enable         (enable),
    .mode           (mode),
    .pkt_len        (pkt_len),
    .seed           (seed),
    .s00_axis_tdata (s00_axis_tdata),
    .s00_axis_tstrb (s00_axis_tstrb),
    .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tlast (s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready),
    .m00_axis_tdata (m00_axis_tdata),
    .m00_axis_tstrb (m00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tlast (m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .fill_level     (fill_level),
    .pkt_sent_count (pkt_sent_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  beat_t         sb[$];
  int            checks    = 0;
  int            errors    = 0;
  int            words_out = 0;
  int            out_base  = 0;
  int            words_in  = 0;
  logic [DW-1:0] inc_next;
  bit            rand_ready = 1'b0;
  bit            ready_level = 1'b0;
  bit            stall = 1'b0;
  beat_t         held, got, exp_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic last, input logic [SW-1:0] strb, input logic [DW-1:0] data);
    beat_t b;
    b = {last, strb, data};
    sb.push_back(b);
  endtask

  task automatic push_inc(input int len);
    for (int i = 0; i < len; i++) begin
      push_beat(i == len - 1, {SW{1'b1}}, inc_next);
      inc_next = inc_next + 1;
    end
    words_in += len;
  endtask

  task automatic start_pkt();
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
  endtask

  // Every issued word is either still held (fill_level) or already transferred.
  task automatic wait_written();
    int t;
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (int'(fill_level) + words_out - out_base != words_in && t < 2000);
    check("written", int'(fill_level) + words_out - out_base, words_in);
  endtask

  task automatic wait_drain(input int exp_pkts);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", sb.size(), 0);
    repeat (4) @(negedge clk);
    check("drain_fill", fill_level, 0);
    check("pkt_sent_count", pkt_sent_count, exp_pkts);
  endtask

  task automatic ext_send(input int n, input logic [DW-1:0] base, input logic [SW-1:0] strb);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = base + DW'(i);
      s00_axis_tstrb  = strb;
      s00_axis_tlast  = (i == n - 1);
      t = 0;
      while (!s00_axis_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("ext_ready", s00_axis_tready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  initial begin
    m00_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m00_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (axis_areset) begin
        stall = 1'b0;
      end else begin
        got = {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
        if (stall) begin
          check("hold_valid", m00_axis_tvalid, 1);
          check("hold_beat", got, held);
        end
        if (m00_axis_tvalid && m00_axis_tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual=%0h required=none", got);
          end else begin
            exp_b = sb.pop_front();
            check("beat", got, exp_b);
          end
          words_out++;
          stall = 1'b0;
        end else if (m00_axis_tvalid) begin
          stall = 1'b1;
          held  = got;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    axis_areset     = 1'b1;
    enable          = 1'b0;
    mode            = 2'd0;
    pkt_len         = LW'(4);
    seed            = 32'h10;
    s00_axis_tdata  = '0;
    s00_axis_tstrb  = '0;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #2 axis_areset = 1'b0;

    @(negedge clk);
    check("rst_tvalid", m00_axis_tvalid, 0);
    check("rst_tlast", m00_axis_tlast, 0);
    check("rst_tdata", m00_axis_tdata, 0);
    check("rst_tstrb", m00_axis_tstrb, 0);
    check("rst_s_tready", s00_axis_tready, 0);
    check("rst_fill", fill_level, 0);
    check("rst_pkt_cnt", pkt_sent_count, 0);
    check("rst_drop_cnt", drop_count, 0);

    // Increment pattern, one packet, plus the 2-cycle commit-to-valid latency.
    ready_level = 1'b1;
    repeat (2) @(negedge clk);
    push_beat(1'b0, 4'hF, 32'h10);
    push_beat(1'b0, 4'hF, 32'h11);
    push_beat(1'b0, 4'hF, 32'h12);
    push_beat(1'b1, 4'hF, 32'h13);
    words_in += 4;
    start_pkt();
    t = 0;
    while (fill_level != 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("lat_fill", fill_level, 4);
    check("lat_edge0", m00_axis_tvalid, 0);
    @(negedge clk);
    check("lat_edge1", m00_axis_tvalid, 0);
    @(negedge clk);
    check("lat_edge2", m00_axis_tvalid, 1);
    wait_drain(1);

    // LFSR from a zero seed, two packets continuing the sequence.
    @(negedge clk);
    mode    = 2'd2;
    seed    = 32'h0;
    pkt_len = LW'(3);
    push_beat(1'b0, 4'hF, 32'h1);
    push_beat(1'b0, 4'hF, 32'h3);
    push_beat(1'b1, 4'hF, 32'h6);
    words_in += 3;
    start_pkt();
    wait_written();
    push_beat(1'b0, 4'hF, 32'hD);
    push_beat(1'b0, 4'hF, 32'h1B);
    push_beat(1'b1, 4'hF, 32'h36);
    words_in += 3;
    start_pkt();
    wait_written();
    wait_drain(3);

    // Full buffer with downstream stalled: generator must stall losslessly.
    @(negedge clk);
    ready_level = 1'b0;
    mode        = 2'd0;
    seed        = 32'h100;
    pkt_len     = LW'(16);
    inc_next    = 32'h100;
    repeat (2) @(negedge clk);
    push_inc(16);
    start_pkt();
    wait_written();
    check("full_fill", fill_level, 16);
    push_inc(16);
    start_pkt();
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk);
      check("stall_fill", fill_level, 16);
    end
    check("stall_tvalid", m00_axis_tvalid, 1);
    ready_level = 1'b1;
    wait_written();
    wait_drain(5);

    // External port: oversize packet dropped, following packet intact.
    @(negedge clk);
    mode = 2'd3;
    ext_send(20, 32'h200, 4'hF);
    push_beat(1'b0, 4'h3, 32'hA);
    push_beat(1'b1, 4'h3, 32'hB);
    words_in += 2;
    ext_send(2, 32'hA, 4'h3);
    mode = 2'd0;
    seed = 32'h1000;
    wait_drain(6);
    check("drop_count", drop_count, 1);

    // 100 packets under random downstream backpressure.
    @(negedge clk);
    pkt_len    = LW'(7);
    inc_next   = 32'h1000;
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      push_inc(7);
      start_pkt();
      wait_written();
    end
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    wait_drain(106);

    // Reset in the middle of a generated packet with three packets stored.
    @(negedge clk);
    ready_level = 1'b0;
    pkt_len     = LW'(4);
    seed        = 32'h40;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      push_inc(4);
      start_pkt();
      wait_written();
    end
    check("pre_rst_fill", fill_level, 12);
    start_pkt();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 axis_areset = 1'b1;
    @(posedge clk); #2 axis_areset = 1'b0;
    sb.delete();
    words_in = 0;
    out_base = words_out;
    inc_next = 32'h40;
    @(negedge clk);
    check("mid_rst_tvalid", m00_axis_tvalid, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_pkt_cnt", pkt_sent_count, 0);
    check("mid_rst_drop_cnt", drop_count, 0);
    ready_level = 1'b1;
    repeat (2) @(negedge clk);
    push_inc(4);
    start_pkt();
    wait_written();
    wait_drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
